// File: rtl/lfsr_rx_pkg.sv
// lfsr_rx_pkg: shared FSM state type and LFSR helpers for the receive decoder
// Contents: state_t {IDLE, SEARCH, OUT}; lfsr_next() one Fibonacci step (widths up to 32);
//           max_step() index of the last state of a maximal-length sequence
package lfsr_rx_pkg;

    typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

    // Bits above the caller's width are don't-care; the caller truncates the result.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int tap_a, input int tap_b);
        return {s[30:0], s[5'(tap_a - 1)] ^ s[5'(tap_b - 1)]};
    endfunction

    function automatic logic [31:0] max_step(input int width);
        return (32'd1 << width) - 32'd2;
    endfunction

endpackage

// File: rtl/lfsr_rx_deser.sv
// lfsr_rx_deser: per-channel serial-to-parallel shifters sharing one bit counter
// Ports: clk_receive, reset (async, active-high); shift_in[CHANNELS] serial bits; shift_en samples them;
//        frame_sync restarts the bit count; word_next = shift registers including this cycle's bit;
//        word_done strobes in the cycle the WIDTH-th bit arrives
module lfsr_rx_deser #(
    parameter int WIDTH    = 15,
    parameter int CHANNELS = 4
) (
    input  logic                      clk_receive,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       shift_in,
    input  logic                      shift_en,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] word_next,
    output logic                      word_done
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]             cnt;
    logic [CHANNELS*WIDTH-1:0] sr;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign word_next[c*WIDTH +: WIDTH] = {sr[c*WIDTH +: WIDTH-1], shift_in[c]};
    end

    // A sync-cycle bit is always bit 1 of a fresh word, so it can never complete one.
    assign word_done = shift_en && !frame_sync && cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk_receive, posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sr  <= '0;
        end else begin
            if (shift_en) sr <= word_next;
            cnt <= frame_sync ? CW'(shift_en) : !shift_en ? cnt : word_done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lfsr_rx_decoder.sv
// lfsr_rx_decoder: multi-channel serial LFSR readout receiver with shared-reference decode
// Ports: clk_receive, reset (async, active-high); shift_in/shift_en/frame_sync serial input;
//        decode_en selects LFSR decode (1) or raw pass-through (0); out_valid/out_ready result handshake;
//        count_out per-channel count (ch0 in LSBs); err_out per-channel word not in sequence;
//        overrun sticky flag for a completed word dropped while busy
module lfsr_rx_decoder import lfsr_rx_pkg::*; #(
    parameter int               WIDTH    = 15,
    parameter int               CHANNELS = 4,
    parameter int               TAP_A    = 14,
    parameter int               TAP_B    = 15,
    parameter logic [WIDTH-1:0] SEED     = '1
) (
    input  logic                      clk_receive,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       shift_in,
    input  logic                      shift_en,
    input  logic                      frame_sync,
    input  logic                      decode_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       err_out,
    output logic                      overrun
);

    localparam logic [WIDTH-1:0] MAX_STEP = WIDTH'(max_step(WIDTH));

    state_t                    state, state_nx;
    logic [CHANNELS*WIDTH-1:0] word_next, hold, result;
    logic [CHANNELS-1:0]       done, match, err;
    logic [WIDTH-1:0]          ref_state, step;
    logic                      word_done, load, search_exit;

    lfsr_rx_deser #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_deser (
        .clk_receive(clk_receive),
        .reset      (reset),
        .shift_in   (shift_in),
        .shift_en   (shift_en),
        .frame_sync (frame_sync),
        .word_next  (word_next),
        .word_done  (word_done)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cmp
        assign match[c] = !done[c] && hold[c*WIDTH +: WIDTH] == ref_state;
    end

    assign load        = word_done && state == IDLE;
    // Exit sees this cycle's matches; MAX_STEP bounds the search so step never wraps.
    assign search_exit = &(done | match) || step == MAX_STEP;
    assign out_valid   = state == OUT;
    assign count_out   = result;
    assign err_out     = err;

    always_ff @(posedge clk_receive, posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (load ? (decode_en ? SEARCH : OUT) : IDLE) :
                   state == SEARCH ? (search_exit ? OUT : SEARCH) :
                                     (out_ready ? IDLE : OUT);
    end

    always_ff @(posedge clk_receive, posedge reset) begin
        if (reset) begin
            hold      <= '0;
            result    <= '0;
            err       <= '0;
            done      <= '0;
            ref_state <= '0;
            step      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (word_done && state != IDLE) overrun <= 1'b1;
            if (load) begin
                hold      <= word_next;
                ref_state <= SEED;
                step      <= '0;
                done      <= '0;
                if (!decode_en) begin
                    result <= word_next;
                    err    <= '0;
                end
            end
            if (state == SEARCH) begin
                ref_state <= WIDTH'(lfsr_next(32'(ref_state), TAP_A, TAP_B));
                step      <= step + WIDTH'(1);
                done      <= done | match;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (match[c]) result[c*WIDTH +: WIDTH] <= step;
                    else if (search_exit && !done[c]) result[c*WIDTH +: WIDTH] <= '1;
                end
                if (search_exit) err <= ~(done | match);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rx_decoder.sv
// tb_lfsr_rx_decoder: scoreboard bench for lfsr_rx_decoder (WIDTH=4, CHANNELS=2, taps 3/4, seed 1111)
// Stimulus pushes hand-computed results into a queue; a negedge monitor pops on each accepted result.
module tb_lfsr_rx_decoder;

    localparam int W = 4;
    localparam int C = 2;

    typedef struct packed {
        logic [C*W-1:0] cnt;
        logic [C-1:0]   err;
    } exp_t;

    logic           clk_receive = 1'b0;
    logic           reset       = 1'b1;
    logic [C-1:0]   shift_in    = '0;
    logic           shift_en    = 1'b0;
    logic           frame_sync  = 1'b0;
    logic           decode_en   = 1'b1;
    logic           out_ready   = 1'b1;
    logic           out_valid;
    logic [C*W-1:0] count_out;
    logic [C-1:0]   err_out;
    logic           overrun;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk_receive = ~clk_receive;

    lfsr_rx_decoder #(.WIDTH(W), .CHANNELS(C), .TAP_A(3), .TAP_B(4), .SEED(4'b1111)) dut (
        .clk_receive(clk_receive),
        .reset      (reset),
        .shift_in   (shift_in),
        .shift_en   (shift_en),
        .frame_sync (frame_sync),
        .decode_en  (decode_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count_out  (count_out),
        .err_out    (err_out),
        .overrun    (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_receive) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got count %0h err %0b, expected none", count_out, err_out);
            end else begin
                e = q.pop_front();
                check("result_count", 32'(count_out), 32'(e.cnt));
                check("result_err", 32'(err_out), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk_receive);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w0, input logic [W-1:0] w1);
        for (int i = W - 1; i >= 0; i--) begin
            shift_in = {w1[i], w0[i]};
            shift_en = 1'b1;
            tick();
        end
        shift_en = 1'b0;
    endtask

    task automatic bit_in(input logic [C-1:0] b, input logic sync);
        shift_in   = b;
        shift_en   = 1'b1;
        frame_sync = sync;
        tick();
        shift_en   = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        check(name, 32'(q.size()), 0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        check(name, 32'(out_valid), 1);
    endtask

    initial begin
        tick();
        tick();
        check("reset_valid", 32'(out_valid), 0);
        check("reset_count", 32'(count_out), 0);
        check("reset_err", 32'(err_out), 0);
        check("reset_overrun", 32'(overrun), 0);
        reset = 1'b0;
        tick();

        // ch0 1000 is step 3, ch1 0001 is step 4: exit on the 5th search cycle
        q.push_back(exp_t'{cnt: 8'h43, err: 2'b00});
        send(4'b1000, 4'b0001);
        repeat (4) tick();
        check("t1_not_yet_valid", 32'(out_valid), 0);
        tick();
        check("t1_valid_latency", 32'(out_valid), 1);
        drain("t1_drain");

        // seed decodes to 0; lockup word never matches, full search through step 14
        q.push_back(exp_t'{cnt: 8'hF0, err: 2'b10});
        send(4'b1111, 4'b0000);
        repeat (14) tick();
        check("t2_not_yet_valid", 32'(out_valid), 0);
        tick();
        check("t2_valid_latency", 32'(out_valid), 1);
        drain("t2_drain");

        decode_en = 1'b0;
        q.push_back(exp_t'{cnt: 8'h5A, err: 2'b00});
        send(4'hA, 4'h5);
        check("t3_valid_next_cycle", 32'(out_valid), 1);
        drain("t3_drain");

        check("t4_overrun_before", 32'(overrun), 0);
        decode_en = 1'b1;
        out_ready = 1'b0;
        q.push_back(exp_t'{cnt: 8'h43, err: 2'b00});
        send(4'b1000, 4'b0001);
        wait_valid("t4_first_valid");
        send(4'b1111, 4'b1110);
        check("t4_count_held", 32'(count_out), 32'h43);
        check("t4_valid_held", 32'(out_valid), 1);
        check("t4_overrun_set", 32'(overrun), 1);
        out_ready = 1'b1;
        drain("t4_drain_first");
        check("t4_overrun_sticky", 32'(overrun), 1);
        q.push_back(exp_t'{cnt: 8'h65, err: 2'b00});
        send(4'b0010, 4'b0100);
        drain("t4_drain_next");
        check("t4_overrun_still", 32'(overrun), 1);

        // two stray bits, then sync bit starts a word: ch0 1011, ch1 0101
        decode_en = 1'b0;
        q.push_back(exp_t'{cnt: 8'h5B, err: 2'b00});
        bit_in(2'b10, 1'b0);
        bit_in(2'b10, 1'b0);
        bit_in(2'b01, 1'b1);
        bit_in(2'b10, 1'b0);
        bit_in(2'b01, 1'b0);
        bit_in(2'b11, 1'b0);
        drain("t5_drain");

        decode_en = 1'b1;
        send(4'b0000, 4'b0000);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("t6_reset_valid", 32'(out_valid), 0);
        check("t6_reset_overrun", 32'(overrun), 0);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check("t6_no_output_after_abort", 32'(out_valid), 0);
        q.push_back(exp_t'{cnt: 8'h43, err: 2'b00});
        send(4'b1000, 4'b0001);
        drain("t6_drain");
        check("t6_overrun_clear", 32'(overrun), 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
